// File: rtl/ahb_crypto_pkg.sv
// Shared constants and types for the AHB crypto slave: register map,
// AHB encodings, FSM states and decoded operation codes.
package ahb_crypto_pkg;

    localparam logic [31:0] ADDR_STATUS   = 32'h0000_0000;
    localparam logic [31:0] ADDR_ENCRYPT  = 32'h0000_0004;
    localparam logic [31:0] ADDR_DECRYPT  = 32'h0000_0008;
    localparam logic [31:0] ADDR_KEY_BASE = 32'h0000_0010;
    localparam logic [31:0] ADDR_DIN_BASE = 32'h0000_0040;
    localparam logic [31:0] ADDR_DOUT     = 32'h0000_0080;

    localparam logic [2:0]  HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_WAIT_RCV,
        S_WAIT_TX,
        S_ERR1,
        S_ERR2
    } state_e;

    // OP_NONE on an accepted address phase means a decode error.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_STATUS,
        OP_ENC,
        OP_DEC,
        OP_KEY,
        OP_DIN,
        OP_DOUT
    } op_e;

    // True when addr is word aligned and lies in [base, base + 4*words).
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned words);
        return (addr[1:0] == 2'b00) && ((addr - base) < 32'(4 * words));
    endfunction

endpackage

// File: rtl/crypto_key_bank.sv
// Key word storage with a written-mask; pulses key_valid once every word
// has been written and tracks whether a complete key is loaded.
module crypto_key_bank #(
    parameter int unsigned KEY_WORDS = 4,
    parameter int unsigned KIDX_W    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [KIDX_W-1:0]         wr_idx,
    input  logic [31:0]               wr_data,
    output logic [32*KEY_WORDS-1:0]   key_out,
    output logic                      key_valid,
    output logic                      key_loaded,
    output logic                      key_loaded_nxt_c
);

    logic [31:0]          key_q [KEY_WORDS];
    logic [31:0]          key_d [KEY_WORDS];
    logic [KEY_WORDS-1:0] mask_q, mask_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_loaded_q, key_loaded_d;

    // A completed mask loads the key and rearms the mask; a partial rewrite
    // invalidates the previously loaded key.
    always_comb begin
        key_d        = key_q;
        mask_d       = mask_q;
        key_valid_d  = 1'b0;
        key_loaded_d = key_loaded_q;
        if (wr_en) begin
            key_d[wr_idx] = wr_data;
            mask_d        = mask_q | (KEY_WORDS'(1) << wr_idx);
            if (&mask_d) begin
                mask_d       = '0;
                key_valid_d  = 1'b1;
                key_loaded_d = 1'b1;
            end else begin
                key_loaded_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
            mask_q       <= '0;
            key_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            key_q        <= key_d;
            mask_q       <= mask_d;
            key_valid_q  <= key_valid_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    // Word 0 lands in the most significant bits.
    always_comb begin
        key_out = '0;
        for (int unsigned i = 0; i < KEY_WORDS; i++) begin
            key_out[32*(KEY_WORDS-1-i) +: 32] = key_q[i];
        end
    end

    assign key_valid        = key_valid_q;
    assign key_loaded       = key_loaded_q;
    assign key_loaded_nxt_c = key_loaded_d;

endmodule

// File: rtl/ahb_crypto_slave.sv
// AHB-Lite slave front end for an AES engine: register decode, key loading,
// FIFO handshakes with wait states, and the two-cycle ERROR response.
module ahb_crypto_slave
    import ahb_crypto_pkg::*;
#(
    parameter int unsigned KEY_WORDS   = 4,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSELx,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADY,
    output logic [1:0]              HRESP,
    input  logic                    rcv_fifo_full,
    output logic                    rcv_enq_word,
    output logic [31:0]             rcv_wdata,
    input  logic                    tx_fifo_empty,
    input  logic [31:0]             tx_rdata,
    output logic                    tx_deq_word,
    input  logic                    engine_busy,
    output logic [32*KEY_WORDS-1:0] key_out,
    output logic                    key_valid,
    output logic                    is_encrypt_pulse,
    output logic                    is_decrypt_pulse
);

    localparam int unsigned KIDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic                enc_pulse_q, enc_pulse_d;
    logic                dec_pulse_q, dec_pulse_d;

    op_e                 dec_op_c;
    logic [KIDX_W-1:0]   dec_kidx_c;
    logic                addr_valid_c;
    logic                hready_c;
    hresp_e              hresp_c;
    logic [31:0]         hrdata_c;
    logic                enq_c, deq_c, key_wr_c;
    logic                key_loaded, key_loaded_nxt_c, key_ok_c;
    logic [31:0]         status_c;
    logic                unused_c;

    assign unused_c     = ^HBURST;
    assign addr_valid_c = HSELx && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign status_c     = {28'b0, rcv_fifo_full, tx_fifo_empty, key_loaded, engine_busy};

    // Key writes never stall, so they only ever complete in DATA.
    assign key_wr_c = !HRESET && (state_q == S_DATA) && (op_q == OP_KEY);
    // A key completing in the current data phase already counts as loaded.
    assign key_ok_c = key_wr_c ? key_loaded_nxt_c : key_loaded;

    // Address-phase decode; anything left at OP_NONE becomes an ERROR.
    always_comb begin
        dec_op_c   = OP_NONE;
        dec_kidx_c = '0;
        if (HSIZE == HSIZE_WORD) begin
            if (HADDR == ADDR_STATUS) begin
                if (!HWRITE) dec_op_c = OP_STATUS;
            end else if (HADDR == ADDR_ENCRYPT) begin
                if (HWRITE && key_ok_c && !engine_busy) dec_op_c = OP_ENC;
            end else if (HADDR == ADDR_DECRYPT) begin
                if (HWRITE && key_ok_c && !engine_busy) dec_op_c = OP_DEC;
            end else if (in_window(HADDR, ADDR_KEY_BASE, KEY_WORDS)) begin
                if (HWRITE) begin
                    dec_op_c   = OP_KEY;
                    dec_kidx_c = KIDX_W'((HADDR - ADDR_KEY_BASE) >> 2);
                end
            end else if (in_window(HADDR, ADDR_DIN_BASE, BLOCK_WORDS)) begin
                if (HWRITE) dec_op_c = OP_DIN;
            end else if (HADDR == ADDR_DOUT) begin
                if (!HWRITE) dec_op_c = OP_DOUT;
            end
        end
    end

    // Data-phase control and next state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        kidx_d      = kidx_q;
        enc_pulse_d = 1'b0;
        dec_pulse_d = 1'b0;
        hready_c    = 1'b1;
        hresp_c     = HRESP_OKAY;
        hrdata_c    = '0;
        enq_c       = 1'b0;
        deq_c       = 1'b0;

        case (state_q)
            S_DATA, S_WAIT_RCV, S_WAIT_TX: begin
                unique case (op_q)
                    OP_STATUS: hrdata_c = status_c;
                    OP_ENC:    enc_pulse_d = 1'b1;
                    OP_DEC:    dec_pulse_d = 1'b1;
                    OP_DIN: begin
                        if (rcv_fifo_full) begin
                            hready_c = 1'b0;
                            state_d  = S_WAIT_RCV;
                        end else begin
                            enq_c = 1'b1;
                        end
                    end
                    OP_DOUT: begin
                        if (tx_fifo_empty) begin
                            hready_c = 1'b0;
                            state_d  = S_WAIT_TX;
                        end else begin
                            deq_c    = 1'b1;
                            hrdata_c = tx_rdata;
                        end
                    end
                    default: ;
                endcase
            end
            S_ERR1: begin
                hready_c = 1'b0;
                hresp_c  = HRESP_ERROR;
                state_d  = S_ERR2;
            end
            S_ERR2:  hresp_c = HRESP_ERROR;
            default: ;
        endcase

        // Completing cycle: take the pending address phase or fall idle.
        if (hready_c) begin
            if (addr_valid_c) begin
                state_d = (dec_op_c == OP_NONE) ? S_ERR1 : S_DATA;
                op_d    = dec_op_c;
                kidx_d  = dec_kidx_c;
            end else begin
                state_d = S_IDLE;
                op_d    = OP_NONE;
            end
        end

        if (HRESET) begin
            hready_c = 1'b1;
            hresp_c  = HRESP_OKAY;
            hrdata_c = '0;
            enq_c    = 1'b0;
            deq_c    = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NONE;
            kidx_q      <= '0;
            enc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            kidx_q      <= kidx_d;
            enc_pulse_q <= enc_pulse_d;
            dec_pulse_q <= dec_pulse_d;
        end
    end

    crypto_key_bank #(
        .KEY_WORDS (KEY_WORDS),
        .KIDX_W    (KIDX_W)
    ) u_key_bank (
        .clk              (HCLK),
        .rst              (HRESET),
        .wr_en            (key_wr_c),
        .wr_idx           (kidx_q),
        .wr_data          (HWDATA),
        .key_out          (key_out),
        .key_valid        (key_valid),
        .key_loaded       (key_loaded),
        .key_loaded_nxt_c (key_loaded_nxt_c)
    );

    assign HREADY           = hready_c;
    assign HRESP            = hresp_c;
    assign HRDATA           = hrdata_c;
    assign rcv_enq_word     = enq_c;
    assign rcv_wdata        = enq_c ? HWDATA : 32'h0;
    assign tx_deq_word      = deq_c;
    assign is_encrypt_pulse = enc_pulse_q;
    assign is_decrypt_pulse = dec_pulse_q;

endmodule

// File: tb/tb_ahb_crypto_slave.sv
// Directed self-checking bench for ahb_crypto_slave with hand-computed expectations.
module tb_ahb_crypto_slave;
    import ahb_crypto_pkg::*;

    localparam int unsigned KW = 4;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic            HSELx;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [31:0]     HWDATA;
    logic [31:0]     HRDATA;
    logic            HREADY;
    logic [1:0]      HRESP;
    logic            rcv_fifo_full;
    logic            rcv_enq_word;
    logic [31:0]     rcv_wdata;
    logic            tx_fifo_empty;
    logic [31:0]     tx_rdata;
    logic            tx_deq_word;
    logic            engine_busy;
    logic [32*KW-1:0] key_out;
    logic            key_valid;
    logic            is_encrypt_pulse;
    logic            is_decrypt_pulse;

    always #5 HCLK = ~HCLK;

    ahb_crypto_slave #(.KEY_WORDS(KW), .BLOCK_WORDS(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELx(HSELx), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .rcv_fifo_full(rcv_fifo_full), .rcv_enq_word(rcv_enq_word),
        .rcv_wdata(rcv_wdata), .tx_fifo_empty(tx_fifo_empty),
        .tx_rdata(tx_rdata), .tx_deq_word(tx_deq_word),
        .engine_busy(engine_busy), .key_out(key_out), .key_valid(key_valid),
        .is_encrypt_pulse(is_encrypt_pulse), .is_decrypt_pulse(is_decrypt_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int kv_cnt = 0, enc_cnt = 0, dec_cnt = 0, enq_cnt = 0, deq_cnt = 0;
    logic [31:0] enq_data = 32'h0;
    logic [2:0]  xsize = 3'b010;

    // Strobe counters sampled mid-cycle.
    always @(negedge HCLK) begin
        if (key_valid)        kv_cnt++;
        if (is_encrypt_pulse) enc_cnt++;
        if (is_decrypt_pulse) dec_cnt++;
        if (tx_deq_word)      deq_cnt++;
        if (rcv_enq_word) begin
            enq_cnt++;
            enq_data = rcv_wdata;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    // Single transfer; sf/se >= 0 hold the FIFO flag stalled for that many data cycles.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int sf, input int se,
                        output logic [31:0] rd, output logic [1:0] r0,
                        output logic [1:0] rl, output int waits);
        HSELx = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = w; HSIZE = xsize;
        cyc();
        HSELx = 1'b0; HTRANS = HTRANS_IDLE; HADDR = 32'h0; HWDATA = wd; HSIZE = 3'b010;
        waits = 0;
        if (sf >= 0) rcv_fifo_full = (waits < sf);
        if (se >= 0) tx_fifo_empty = (waits < se);
        #1;
        r0 = HRESP;
        while (!HREADY && waits < 20) begin
            waits++;
            cyc();
            if (sf >= 0) rcv_fifo_full = (waits < sf);
            if (se >= 0) tx_fifo_empty = (waits < se);
            #1;
        end
        rd = HRDATA;
        rl = HRESP;
        cyc();
        rcv_fifo_full = 1'b0;
        tx_fifo_empty = 1'b1;
    endtask

    logic [31:0] rd;
    logic [1:0]  r0, rl;
    int          w;
    int          snap;

    initial begin
        HRESET = 1'b1; HSELx = 1'b0; HADDR = 32'h0; HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0; HSIZE = 3'b010; HBURST = 3'b000; HWDATA = 32'h0;
        rcv_fifo_full = 1'b0; tx_fifo_empty = 1'b1; tx_rdata = 32'h0; engine_busy = 1'b0;
        repeat (3) cyc();
        #1;
        chk("rst_hready", 128'(HREADY), 128'd1);
        chk("rst_hresp", 128'(HRESP), 128'd0);
        chk("rst_hrdata", 128'(HRDATA), 128'd0);
        chk("rst_key_out", 128'(key_out), 128'd0);
        chk("rst_strobes", 128'({key_valid, is_encrypt_pulse, is_decrypt_pulse,
                                 rcv_enq_word, tx_deq_word}), 128'd0);
        HRESET = 1'b0;
        cyc();

        // Status read after reset: only tx_fifo_empty set.
        xfer(ADDR_STATUS, 1'b0, 32'h0, -1, -1, rd, r0, rl, w);
        chk("status_rdata", 128'(rd), 128'h4);
        chk("status_resp", 128'(rl), 128'd0);
        chk("status_waits", 128'(w), 128'd0);

        // Encrypt with no key loaded: two-cycle error, no pulse.
        snap = enc_cnt;
        xfer(ADDR_ENCRYPT, 1'b1, 32'h0, -1, -1, rd, r0, rl, w);
        chk("enc_nokey_resp1", 128'(r0), 128'd1);
        chk("enc_nokey_waits", 128'(w), 128'd1);
        chk("enc_nokey_resp2", 128'(rl), 128'd1);
        repeat (2) cyc();
        chk("enc_nokey_pulse", 128'(enc_cnt - snap), 128'd0);

        // INCR4 key burst 0x10..0x1C, back-to-back data phases.
        snap = kv_cnt;
        HSELx = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = ADDR_KEY_BASE; HWRITE = 1'b1; HBURST = 3'b011;
        for (int i = 0; i < 4; i++) begin
            cyc();
            HWDATA = 32'h0001_0203 + 32'(i) * 32'h0404_0404;
            if (i < 3) begin
                HTRANS = HTRANS_SEQ;
                HADDR  = ADDR_KEY_BASE + 32'(4 * (i + 1));
            end else begin
                HSELx = 1'b0; HTRANS = HTRANS_IDLE; HADDR = 32'h0; HBURST = 3'b000;
            end
            #1;
            chk("key_burst_hready", 128'(HREADY), 128'd1);
            chk("key_burst_hrdata", 128'(HRDATA), 128'd0);
        end
        cyc();
        chk("key_valid_pulse", 128'(key_valid), 128'd1);
        chk("key_out", 128'(key_out), 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F);
        repeat (3) cyc();
        chk("key_valid_count", 128'(kv_cnt - snap), 128'd1);

        xfer(ADDR_STATUS, 1'b0, 32'h0, -1, -1, rd, r0, rl, w);
        chk("status_keyed", 128'(rd), 128'h6);

        // Encrypt with key loaded: one-cycle pulse.
        snap = enc_cnt;
        xfer(ADDR_ENCRYPT, 1'b1, 32'h0, -1, -1, rd, r0, rl, w);
        chk("enc_ok_resp", 128'(rl), 128'd0);
        chk("enc_ok_waits", 128'(w), 128'd0);
        #1;
        chk("enc_pulse_hi", 128'(is_encrypt_pulse), 128'd1);
        cyc();
        chk("enc_pulse_lo", 128'(is_encrypt_pulse), 128'd0);
        repeat (2) cyc();
        chk("enc_pulse_count", 128'(enc_cnt - snap), 128'd1);

        // Decrypt while the engine is busy is an error; then succeeds.
        snap = dec_cnt;
        engine_busy = 1'b1;
        xfer(ADDR_DECRYPT, 1'b1, 32'h0, -1, -1, rd, r0, rl, w);
        engine_busy = 1'b0;
        chk("dec_busy_resp", 128'(rl), 128'd1);
        xfer(ADDR_DECRYPT, 1'b1, 32'h0, -1, -1, rd, r0, rl, w);
        chk("dec_ok_resp", 128'(rl), 128'd0);
        repeat (2) cyc();
        chk("dec_pulse_count", 128'(dec_cnt - snap), 128'd1);

        // Data-in with FIFO full for three data cycles.
        snap = enq_cnt;
        xfer(ADDR_DIN_BASE + 32'h4, 1'b1, 32'hCAFE_F00D, 3, -1, rd, r0, rl, w);
        chk("din_waits", 128'(w), 128'd3);
        chk("din_resp", 128'(rl), 128'd0);
        chk("din_enq_count", 128'(enq_cnt - snap), 128'd1);
        chk("din_enq_data", 128'(enq_data), 128'hCAFE_F00D);

        // Data-out with FIFO empty for two data cycles.
        snap = deq_cnt;
        tx_rdata = 32'hDEAD_BEEF;
        xfer(ADDR_DOUT, 1'b0, 32'h0, -1, 2, rd, r0, rl, w);
        chk("dout_waits", 128'(w), 128'd2);
        chk("dout_rdata", 128'(rd), 128'hDEAD_BEEF);
        chk("dout_deq_count", 128'(deq_cnt - snap), 128'd1);
        #1;
        chk("dout_hrdata_idle", 128'(HRDATA), 128'd0);

        // Unmapped address.
        xfer(32'h0000_0128, 1'b1, 32'h0, -1, -1, rd, r0, rl, w);
        chk("bad_addr_resp1", 128'(r0), 128'd1);
        chk("bad_addr_waits", 128'(w), 128'd1);
        chk("bad_addr_resp2", 128'(rl), 128'd1);
        #1;
        chk("bad_addr_after_hready", 128'(HREADY), 128'd1);
        chk("bad_addr_after_resp", 128'(HRESP), 128'd0);

        // Wrong direction, wrong size, key index out of range.
        xfer(ADDR_ENCRYPT, 1'b0, 32'h0, -1, -1, rd, r0, rl, w);
        chk("wrong_dir_resp", 128'(rl), 128'd1);
        xsize = 3'b000;
        xfer(ADDR_STATUS, 1'b0, 32'h0, -1, -1, rd, r0, rl, w);
        xsize = 3'b010;
        chk("bad_size_resp", 128'(rl), 128'd1);
        xfer(ADDR_KEY_BASE + 32'h10, 1'b1, 32'h0, -1, -1, rd, r0, rl, w);
        chk("key_idx_range_resp", 128'(rl), 128'd1);

        // Address phase shown only during the first error cycle is dropped.
        snap = enc_cnt;
        HSELx = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0000_0128; HWRITE = 1'b1;
        cyc();
        HADDR = ADDR_ENCRYPT;
        #1;
        chk("err1_hready", 128'(HREADY), 128'd0);
        chk("err1_hresp", 128'(HRESP), 128'd1);
        cyc();
        HSELx = 1'b0; HTRANS = HTRANS_IDLE; HADDR = 32'h0;
        #1;
        chk("err2_hready", 128'(HREADY), 128'd1);
        chk("err2_hresp", 128'(HRESP), 128'd1);
        repeat (3) cyc();
        chk("err1_discard_pulse", 128'(enc_cnt - snap), 128'd0);

        // Reset during a stalled data-in write: no enqueue, key cleared.
        snap = enq_cnt;
        HSELx = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = ADDR_DIN_BASE; HWRITE = 1'b1;
        cyc();
        HSELx = 1'b0; HTRANS = HTRANS_IDLE; HADDR = 32'h0; HWDATA = 32'h1111_2222;
        rcv_fifo_full = 1'b1;
        #1;
        chk("midrst_stall", 128'(HREADY), 128'd0);
        cyc();
        HRESET = 1'b1; rcv_fifo_full = 1'b0;
        #1;
        chk("midrst_no_enq", 128'(rcv_enq_word), 128'd0);
        chk("midrst_hready", 128'(HREADY), 128'd1);
        cyc();
        HRESET = 1'b0;
        #1;
        chk("midrst_key_clear", 128'(key_out), 128'd0);
        cyc();
        chk("midrst_enq_count", 128'(enq_cnt - snap), 128'd0);
        xfer(ADDR_STATUS, 1'b0, 32'h0, -1, -1, rd, r0, rl, w);
        chk("midrst_status", 128'(rd), 128'h4);

        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
